cdc_fifo_writer: RTL

- Write-side feeder for the async gray-pointer CDC FIFO.
- Accepts a framed valid/ready word stream in the wclk domain and pushes tagged words into the FIFO write port, honouring its registered full flag.
- Tags each word with start-of-frame, end-of-frame and error bits so the read side can re-frame.
- Holds a 2-entry skid buffer for a registered src_ready; optional drop mode never back-pressures the source.

---
 rtl/cdc_fifo_writer.sv | 105 ++++++++++
 1 files changed

// File: rtl/cdc_fifo_writer.sv
// cdc_fifo_writer: wclk-domain feeder that frames a valid/ready stream into tagged words for the async CDC FIFO.
// Each FIFO word is {err, sof, eof, data}. A two-entry skid buffer holds words while the FIFO is full.
// With drop_en set, the source is never stalled. A word that arrives while both buffer entries are full
// and nothing drains is dropped, and the next word stored carries err=1.
// Optional build macro CDC_FIFO_WRITER_STATS_EN implements frame_cnt and lost_cnt.
// When the macro is not defined, both counters read 0.
module cdc_fifo_writer #(
    parameter int DSIZE = 32
) (
    input  logic             wclk,
    input  logic             rrst,
    input  logic             drop_en,
    input  logic [DSIZE-1:0] src_data,
    input  logic             src_valid,
    input  logic             src_last,
    output logic             src_ready,
    output logic [DSIZE+2:0] fifo_wdata,
    output logic             fifo_winc,
    input  logic             fifo_wfull,
    output logic [15:0]      frame_cnt,
    output logic [7:0]       lost_cnt
);
    localparam int W = DSIZE + 3;

    typedef enum logic {IDLE, FRAME} state_t;

    state_t         state, state_n;
    logic           head_valid, skid_valid, rdy_q, err_pending;
    logic [W-1:0]   head_data, skid_data;
    logic           head_valid_n, skid_valid_n, err_pending_n, head_free;
    logic [W-1:0]   head_data_n, skid_data_n, new_word;
    logic           adv, drop, store, sof;

    assign src_ready  = ~rrst & (drop_en | rdy_q);
    assign fifo_winc  = ~rrst & head_valid & ~fifo_wfull;
    assign fifo_wdata = rrst ? '0 : head_data;
    assign adv        = src_valid & src_ready;
    assign drop       = adv & head_valid & skid_valid & ~fifo_winc;
    assign store      = adv & ~drop;

    // Framer state register
    always_ff @(posedge wclk) begin
        if (rrst) state <= IDLE;
        else      state <= state_n;
    end

    // Framer: every source word, whether stored or dropped, advances the frame position
    always_comb begin
        state_n = state;
        sof     = (state == IDLE);
        if (adv) state_n = src_last ? IDLE : FRAME;
    end

    // Skid buffer next state: skid refills head on drain; new word goes to head when it frees up
    always_comb begin
        new_word      = {err_pending, sof, src_last, src_data};
        head_free     = ~head_valid | fifo_winc;
        head_valid_n  = head_free ? (skid_valid | store) : 1'b1;
        head_data_n   = head_free ? (skid_valid ? skid_data : new_word) : head_data;
        skid_valid_n  = head_free ? (skid_valid & store) : (skid_valid | store);
        skid_data_n   = store ? new_word : skid_data;
        err_pending_n = drop ? 1'b1 : (store ? 1'b0 : err_pending);
    end

    // Buffer, ready and error registers
    always_ff @(posedge wclk) begin
        if (rrst) begin
            head_valid  <= 1'b0;
            skid_valid  <= 1'b0;
            head_data   <= '0;
            skid_data   <= '0;
            rdy_q       <= 1'b0;
            err_pending <= 1'b0;
        end else begin
            head_valid  <= head_valid_n;
            skid_valid  <= skid_valid_n;
            head_data   <= head_data_n;
            skid_data   <= skid_data_n;
            rdy_q       <= ~skid_valid_n;
            err_pending <= err_pending_n;
        end
    end

`ifdef CDC_FIFO_WRITER_STATS_EN
    logic [15:0] frame_q;
    logic [7:0]  lost_q;

    // Frame counter wraps; lost counter saturates at 255
    always_ff @(posedge wclk) begin
        if (rrst) begin
            frame_q <= '0;
            lost_q  <= '0;
        end else begin
            if (fifo_winc && head_data[DSIZE]) frame_q <= frame_q + 16'd1;
            if (drop && lost_q != 8'hff)       lost_q  <= lost_q + 8'd1;
        end
    end

    assign frame_cnt = frame_q;
    assign lost_cnt  = lost_q;
`else
    assign frame_cnt = '0;
    assign lost_cnt  = '0;
`endif
endmodule
